// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and counter sizing for serial_subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// full_sub_cell: one-bit full subtractor, d = a - b - bin with borrow out.
module full_sub_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A - B, LSB first, start/done handshake.
// Define SERIAL_SUB_SAT_EN to clamp an underflowing result to zero.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, diff_q, diff_d;
    logic             br_q, br_d, borrow_q, borrow_d, zero_q, zero_d;
    logic             d, bout, last;
    logic [WIDTH-1:0] sh_next, res;

    full_sub_cell u_cell (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .bin_i (br_q),
        .d_o   (d),
        .bout_o(bout)
    );

    assign last    = cnt_q == CW'(WIDTH - 1);
    // Partial result lives in sh_q so Diff stays frozen until the final edge.
    assign sh_next = (sh_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
`ifdef SERIAL_SUB_SAT_EN
    assign res     = bout ? '0 : sh_next;
`else
    assign res     = sh_next;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: if (Start) begin
                state_d  = SHIFT;
                cnt_d    = '0;
                a_d      = A;
                b_d      = B;
                sh_d     = '0;
                br_d     = 1'b0;
                diff_d   = '0;
                borrow_d = 1'b0;
                zero_d   = 1'b0;
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sh_d  = sh_next;
                br_d  = bout;
                if (last) begin
                    state_d  = DONE;
                    diff_d   = res;
                    borrow_d = bout;
                    zero_d   = ~|res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign Ready  = state_q == IDLE;
    assign Busy   = state_q == SHIFT;
    assign Done   = state_q == DONE;
    assign Diff   = diff_q;
    assign Borrow = borrow_q;
    assign Zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s8 = 1'b0, r8, busy8, done8, bor8, z8;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic s1 = 1'b0, r1, busy1, done1, bor1, z1;
    logic [0:0] a1 = '0, b1 = '0, diff1;
    int pass = 0, total = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .Start(s8), .A(a8), .B(b8), .Ready(r8), .Busy(busy8),
        .Done(done8), .Diff(diff8), .Borrow(bor8), .Zero(z8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Start(s1), .A(a1), .B(b1), .Ready(r1), .Busy(busy1),
        .Done(done1), .Diff(diff1), .Borrow(bor1), .Zero(z1)
    );

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                       input logic eb, input logic ez, input string nm);
        logic ok;
        @(negedge clk); s8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk); s8 = 1'b0;
        ok = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge clk);
            if (!(busy8 === 1'b1 && done8 === 1'b0 && r8 === 1'b0 && diff8 === 8'h00)) ok = 1'b0;
        end
        total++;
        if (ok !== 1'b1) $display("FAIL %s busy window: got ok=%b, required 1", nm, ok);
        else pass++;
        @(negedge clk);
        total++;
        if ({done8, busy8, diff8, bor8, z8} !== {1'b1, 1'b0, ed, eb, ez})
            $display("FAIL %s done: got done=%b busy=%b diff=%h borrow=%b zero=%b, required 1 0 %h %b %b",
                     nm, done8, busy8, diff8, bor8, z8, ed, eb, ez);
        else pass++;
        @(negedge clk);
        total++;
        if ({r8, done8, diff8, bor8, z8} !== {1'b1, 1'b0, ed, eb, ez})
            $display("FAIL %s idle: got ready=%b done=%b diff=%h, required 1 0 %h", nm, r8, done8, diff8, ed);
        else pass++;
    endtask

    task automatic op1(input logic a, input logic b, input logic ed, input logic eb,
                       input logic ez, input string nm);
        @(negedge clk); s1 = 1'b1; a1 = a; b1 = b;
        @(negedge clk); s1 = 1'b0;
        total++;
        if ({busy1, done1, r1} !== 3'b100)
            $display("FAIL %s busy: got busy=%b done=%b ready=%b, required 1 0 0", nm, busy1, done1, r1);
        else pass++;
        @(negedge clk);
        total++;
        if ({done1, diff1, bor1, z1} !== {1'b1, ed, eb, ez})
            $display("FAIL %s done: got done=%b diff=%b borrow=%b zero=%b, required 1 %b %b %b",
                     nm, done1, diff1, bor1, z1, ed, eb, ez);
        else pass++;
        @(negedge clk);
        total++;
        if ({r1, done1} !== 2'b10) $display("FAIL %s idle: got ready=%b done=%b, required 1 0", nm, r1, done1);
        else pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({r8, busy8, done8, diff8, bor8, z8} !== {3'b100, 8'h00, 2'b00})
            $display("FAIL reset8: got ready=%b busy=%b done=%b diff=%h borrow=%b zero=%b, required 1 0 0 00 0 0",
                     r8, busy8, done8, diff8, bor8, z8);
        else pass++;
        total++;
        if ({r1, busy1, done1, diff1, bor1, z1} !== 6'b100000)
            $display("FAIL reset1: got ready=%b busy=%b done=%b diff=%b borrow=%b zero=%b, required 1 0 0 0 0 0",
                     r1, busy1, done1, diff1, bor1, z1);
        else pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_width8();
        op8(8'd200, 8'd55,  8'd145, 1'b0, 1'b0, "w8_200_55");
        op8(8'd55,  8'd200, SAT ? 8'h00 : 8'h6F, 1'b1, SAT, "w8_55_200");
        op8(8'hAA,  8'hAA,  8'h00, 1'b0, 1'b1, "w8_aa_aa");
        op8(8'h00,  8'h01,  SAT ? 8'h00 : 8'hFF, 1'b1, SAT, "w8_0_1");
        op8(8'hFF,  8'h00,  8'hFF, 1'b0, 1'b0, "w8_ff_0");
    endtask

    task automatic test_width1();
        op1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "w1_00");
        op1(1'b0, 1'b1, SAT ? 1'b0 : 1'b1, 1'b1, SAT, "w1_01");
        op1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "w1_10");
        op1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "w1_11");
    endtask

    task automatic test_start_held();
        logic ok;
        @(negedge clk); s8 = 1'b1; a8 = 8'd200; b8 = 8'd55;
        @(negedge clk); a8 = 8'd9; b8 = 8'd4;
        ok = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge clk);
            if (busy8 !== 1'b1) ok = 1'b0;
        end
        total++;
        if (ok !== 1'b1) $display("FAIL held busy: got ok=%b, required 1", ok);
        else pass++;
        @(negedge clk);
        total++;
        if ({done8, diff8, bor8} !== {1'b1, 8'd145, 1'b0})
            $display("FAIL held first: got done=%b diff=%0d borrow=%b, required 1 145 0", done8, diff8, bor8);
        else pass++;
        @(negedge clk);
        total++;
        if ({r8, diff8} !== {1'b1, 8'd145})
            $display("FAIL held ready: got ready=%b diff=%0d, required 1 145", r8, diff8);
        else pass++;
        @(negedge clk); s8 = 1'b0;
        total++;
        if ({busy8, diff8} !== {1'b1, 8'd0})
            $display("FAIL held accept: got busy=%b diff=%0d, required 1 0", busy8, diff8);
        else pass++;
        repeat (8) @(negedge clk);
        total++;
        if ({done8, diff8, bor8, z8} !== {1'b1, 8'd5, 2'b00})
            $display("FAIL held second: got done=%b diff=%0d borrow=%b zero=%b, required 1 5 0 0", done8, diff8, bor8, z8);
        else pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk); s8 = 1'b1; a8 = 8'd200; b8 = 8'd55;
        @(negedge clk); s8 = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy8 !== 1'b1) $display("FAIL midrst pre: got busy=%b, required 1", busy8);
        else pass++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({r8, busy8, done8, diff8, bor8, z8} !== {3'b100, 8'h00, 2'b00})
            $display("FAIL midrst async: got ready=%b busy=%b done=%b diff=%h borrow=%b zero=%b, required 1 0 0 00 0 0",
                     r8, busy8, done8, diff8, bor8, z8);
        else pass++;
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 !== 1'b0 || r8 !== 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL midrst quiet: got stray=%b, required 0", seen);
        else pass++;
        op8(8'd100, 8'd1, 8'd99, 1'b0, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        op8(8'd10, 8'd3,  8'd7,  1'b0, 1'b0, "b2b_a");
        op8(8'd3,  8'd10, SAT ? 8'h00 : 8'hF9, 1'b1, SAT, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_width8();
        test_width1();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
